dconv_weight_arb: RTL and testbench

DCONV_WEIGHT_ARB -- requirements
Module: dconv_weight_arb

---
 rtl/dconv_weight_arb_pkg.sv | 23 ++
 rtl/dconv_weight_arb_if.sv | 34 +++
 rtl/dconv_weight_arb_rr_arbiter.sv | 45 ++++
 rtl/dconv_weight_arb.sv | 134 +++++++++++++
 tb/tb_dconv_weight_arb.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/dconv_weight_arb_pkg.sv
// Shared types and constants for the depthwise-conv weight SRAM arbiter.
package dconv_weight_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    localparam int MAX_BURST_LEN = 16;
    localparam int WORD_STRIDE   = 4;

    // Requested lengths of 0 still fetch one word; anything past the limit is clipped.
    function automatic logic [3:0] last_word_idx(input logic [4:0] len);
        if (len == 5'd0) begin
            return 4'd0;
        end else if (len > 5'(MAX_BURST_LEN)) begin
            return 4'(MAX_BURST_LEN - 1);
        end else begin
            return 4'(len - 5'd1);
        end
    endfunction

endpackage

// File: rtl/dconv_weight_arb_if.sv
// Lane request / SRAM / return-data bundle between the conv lanes and the weight arbiter.
interface dconv_weight_arb_if #(
    parameter int NUM_LANES = 4,
    parameter int ADDR_W    = 12,
    parameter int DATA_W    = 32
);

    logic [NUM_LANES-1:0]             req;
    logic [NUM_LANES-1:0][ADDR_W-1:0] req_addr;
    logic [NUM_LANES-1:0][4:0]        req_len;
    logic [NUM_LANES-1:0]             grant;
    logic                             mem_rd_en;
    logic [ADDR_W-1:0]                mem_rd_addr;
    logic [DATA_W-1:0]                mem_rdata;
    logic [NUM_LANES-1:0]             rdata_valid;
    logic [DATA_W-1:0]                rdata;
    logic [3:0]                       rdata_idx;
    logic [NUM_LANES-1:0]             burst_done;
    logic                             layer_done_in;
    logic                             layer_done_out;

    modport slave (
        input  req, req_addr, req_len, mem_rdata, layer_done_in,
        output grant, mem_rd_en, mem_rd_addr, rdata_valid, rdata, rdata_idx,
               burst_done, layer_done_out
    );

    modport master (
        output req, req_addr, req_len, mem_rdata, layer_done_in,
        input  grant, mem_rd_en, mem_rd_addr, rdata_valid, rdata, rdata_idx,
               burst_done, layer_done_out
    );

endinterface

// File: rtl/dconv_weight_arb_rr_arbiter.sv
// Round-robin one-hot picker; the search starts one lane past the last lane that won.
module rr_arbiter #(
    parameter  int NUM_LANES = 4,
    localparam int IDX_W     = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_LANES-1:0] req,
    input  logic                 advance,
    output logic [NUM_LANES-1:0] pick,
    output logic [IDX_W-1:0]     pick_idx,
    output logic                 pick_valid
);

    logic [IDX_W-1:0] ptr;
    int               cand;

    always_comb begin
        pick       = '0;
        pick_idx   = '0;
        pick_valid = 1'b0;
        cand       = 0;
        for (int i = 1; i <= NUM_LANES; i++) begin
            cand = int'(ptr) + i;
            if (cand >= NUM_LANES) begin
                cand = cand - NUM_LANES;
            end
            if (!pick_valid && req[cand[IDX_W-1:0]]) begin
                pick_valid = 1'b1;
                pick_idx   = cand[IDX_W-1:0];
                pick       = NUM_LANES'(1) << cand[IDX_W-1:0];
            end
        end
    end

    // Pointer resets to the top lane so lane 0 has first priority.
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr <= IDX_W'(NUM_LANES - 1);
        end else if (advance && pick_valid) begin
            ptr <= pick_idx;
        end
    end

endmodule

// File: rtl/dconv_weight_arb.sv
// Shares one weight SRAM between depthwise-conv lanes: round-robin burst grants,
// one read per cycle, return data tagged with owning lane and kernel slot.
module dconv_weight_arb #(
    parameter int NUM_LANES = 4,
    parameter int ADDR_W    = 12,
    parameter int DATA_W    = 32
) (
    input logic               clk,
    input logic               reset,
    dconv_weight_arb_if.slave bus
);

    import dconv_weight_arb_pkg::*;

    localparam int IDX_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;

    state_t               state;
    state_t               next_state;
    logic                 take;
    logic                 issue;
    logic [NUM_LANES-1:0] pick;
    logic [IDX_W-1:0]     pick_idx;
    logic                 pick_valid;

    logic [ADDR_W-1:0]    cur_addr;
    logic [3:0]           word_idx;
    logic [3:0]           last_idx;
    logic [IDX_W-1:0]     cur_lane;

    logic                 tag_valid;
    logic                 tag_last;
    logic [IDX_W-1:0]     tag_lane;
    logic [3:0]           tag_idx;
    logic                 ret_valid;
    logic [NUM_LANES-1:0] ret_lane;
    logic [DATA_W-1:0]    ret_data;
    logic                 done_flag;

    rr_arbiter #(.NUM_LANES(NUM_LANES)) u_arb (
        .clk        (clk),
        .reset      (reset),
        .req        (bus.req),
        .advance    (take),
        .pick       (pick),
        .pick_idx   (pick_idx),
        .pick_valid (pick_valid)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Reset masks take/issue so nothing is granted or read while reset is held.
    always_comb begin
        next_state = state;
        take       = 1'b0;
        issue      = 1'b0;
        if (!reset) begin
            case (state)
                IDLE: begin
                    if (!bus.layer_done_in && pick_valid) begin
                        take       = 1'b1;
                        next_state = BURST;
                    end
                end
                BURST: begin
                    issue = 1'b1;
                    if (word_idx == last_idx) begin
                        next_state = IDLE;
                    end
                end
                default: next_state = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cur_addr <= '0;
            word_idx <= '0;
            last_idx <= '0;
            cur_lane <= '0;
        end else if (take) begin
            cur_addr <= bus.req_addr[pick_idx];
            last_idx <= last_word_idx(bus.req_len[pick_idx]);
            word_idx <= '0;
            cur_lane <= pick_idx;
        end else if (issue) begin
            cur_addr <= cur_addr + ADDR_W'(WORD_STRIDE);
            word_idx <= word_idx + 4'd1;
        end
    end

    // The tag trails each read by one cycle, lining up with the SRAM data.
    always_ff @(posedge clk) begin
        if (reset) begin
            tag_valid <= 1'b0;
            tag_last  <= 1'b0;
            tag_lane  <= '0;
            tag_idx   <= '0;
        end else begin
            tag_valid <= issue;
            tag_last  <= issue && (word_idx == last_idx);
            tag_lane  <= cur_lane;
            tag_idx   <= word_idx;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            done_flag <= 1'b0;
        end else if (state == IDLE && bus.layer_done_in) begin
            done_flag <= 1'b1;
        end
    end

    assign ret_valid = tag_valid && !reset;
    assign ret_lane  = NUM_LANES'(1) << tag_lane;
    assign ret_data  = ret_valid ? bus.mem_rdata : '0;

    assign bus.grant          = take ? pick : '0;
    assign bus.mem_rd_en      = issue;
    assign bus.mem_rd_addr    = issue ? cur_addr : '0;
    assign bus.rdata_valid    = ret_valid ? ret_lane : '0;
    assign bus.rdata          = ret_data;
    assign bus.rdata_idx      = ret_valid ? tag_idx : 4'd0;
    assign bus.burst_done     = (ret_valid && tag_last) ? ret_lane : '0;
    assign bus.layer_done_out = done_flag;

endmodule

// File: tb/tb_dconv_weight_arb.sv
// Scoreboard bench for dconv_weight_arb: directed lane traffic, cycle-stamped expectations.
module tb_dconv_weight_arb;

    typedef struct { int lane; int cyc; } grant_exp_t;
    typedef struct { logic [11:0] addr; int cyc; } read_exp_t;
    typedef struct { int lane; int idx; logic [31:0] data; bit done; int cyc; } rsp_exp_t;

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    logic [3:0] hold_mask;

    grant_exp_t grant_q[$];
    read_exp_t  read_q[$];
    rsp_exp_t   rsp_q[$];

    dconv_weight_arb_if #(.NUM_LANES(4), .ADDR_W(12), .DATA_W(32)) bus ();

    dconv_weight_arb #(.NUM_LANES(4), .ADDR_W(12), .DATA_W(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] sram_word(input logic [11:0] a);
        return {20'hC0DE0, a};
    endfunction

    function automatic logic [3:0] onehot(input int lane);
        return 4'(1 << lane);
    endfunction

    // Synchronous SRAM: data one cycle after the strobe, junk otherwise.
    always @(posedge clk) begin
        bus.mem_rdata <= bus.mem_rd_en ? sram_word(bus.mem_rd_addr) : 32'hDEAD_BEEF;
    end

    task automatic check_output(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    task automatic expect_burst(input int lane, input logic [11:0] addr, input logic [4:0] len, input int g);
        int eff;
        eff = (len == 5'd0) ? 1 : (len > 5'd16) ? 16 : int'(len);
        grant_q.push_back('{lane: lane, cyc: g});
        for (int i = 0; i < eff; i++) begin
            logic [11:0] a;
            a = addr + 12'(4 * i);
            read_q.push_back('{addr: a, cyc: g + 1 + i});
            rsp_q.push_back('{lane: lane, idx: i, data: sram_word(a), done: (i == eff - 1), cyc: g + 2 + i});
        end
    endtask

    task automatic apply_stimulus(input int lane, input logic [11:0] addr, input logic [4:0] len);
        bus.req_addr[2'(lane)] = addr;
        bus.req_len[2'(lane)]  = len;
        bus.req[2'(lane)]      = 1'b1;
    endtask

    // One clock; a granted lane drops its request unless it is held continuously.
    task automatic tick();
        logic [3:0] g;
        @(negedge clk);
        g = bus.grant;
        @(posedge clk);
        #1;
        bus.req = bus.req & ~(g & ~hold_mask);
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        repeat (n) tick();
        reset = 1'b0;
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            if (bus.grant != 4'd0) begin
                if (grant_q.size() == 0) begin
                    check_output("grant_unexpected", 64'(bus.grant), 64'd0);
                end else begin
                    grant_exp_t e;
                    e = grant_q.pop_front();
                    check_output("grant_lane", 64'(bus.grant), 64'(onehot(e.lane)));
                    check_output("grant_cycle", 64'(cyc), 64'(e.cyc));
                end
            end
            if (bus.mem_rd_en) begin
                if (read_q.size() == 0) begin
                    check_output("read_unexpected", 64'(bus.mem_rd_addr), 64'hFFFF);
                end else begin
                    read_exp_t r;
                    r = read_q.pop_front();
                    check_output("read_addr", 64'(bus.mem_rd_addr), 64'(r.addr));
                    check_output("read_cycle", 64'(cyc), 64'(r.cyc));
                end
            end else begin
                check_output("read_addr_idle", 64'(bus.mem_rd_addr), 64'd0);
            end
            if (bus.rdata_valid != 4'd0) begin
                if (rsp_q.size() == 0) begin
                    check_output("rsp_unexpected", 64'(bus.rdata_valid), 64'd0);
                end else begin
                    rsp_exp_t s;
                    s = rsp_q.pop_front();
                    check_output("rsp_lane", 64'(bus.rdata_valid), 64'(onehot(s.lane)));
                    check_output("rsp_idx", 64'(bus.rdata_idx), 64'(s.idx));
                    check_output("rsp_data", 64'(bus.rdata), 64'(s.data));
                    check_output("rsp_done", 64'(bus.burst_done), s.done ? 64'(onehot(s.lane)) : 64'd0);
                    check_output("rsp_cycle", 64'(cyc), 64'(s.cyc));
                end
            end else begin
                check_output("rsp_idle", 64'({bus.rdata, bus.rdata_idx, bus.burst_done}), 64'd0);
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog expired actual=running required=finished");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int n;
        int m;
        reset             = 1'b1;
        hold_mask         = 4'b0000;
        bus.req           = '0;
        bus.req_addr      = '0;
        bus.req_len       = '0;
        bus.layer_done_in = 1'b0;
        repeat (3) tick();
        reset = 1'b0;

        $display("[TB] reset state");
        check_output("rst_grant", 64'(bus.grant), 64'd0);
        check_output("rst_rd_en", 64'(bus.mem_rd_en), 64'd0);
        check_output("rst_rd_addr", 64'(bus.mem_rd_addr), 64'd0);
        check_output("rst_rdata_valid", 64'(bus.rdata_valid), 64'd0);
        check_output("rst_layer_done", 64'(bus.layer_done_out), 64'd0);

        $display("[TB] single lane burst");
        n = cyc;
        apply_stimulus(0, 12'h010, 5'd4);
        expect_burst(0, 12'h010, 5'd4, n);
        repeat (8) tick();

        $display("[TB] four lanes after reset");
        do_reset(2);
        n = cyc;
        for (int l = 0; l < 4; l++) begin
            apply_stimulus(l, 12'(12'h100 * (l + 1)), 5'd4);
            expect_burst(l, 12'(12'h100 * (l + 1)), 5'd4, n + 5 * l);
        end
        repeat (22) tick();

        $display("[TB] fairness lanes 1 and 3");
        n = cyc;
        hold_mask = 4'b1010;
        apply_stimulus(1, 12'h040, 5'd2);
        apply_stimulus(3, 12'h080, 5'd2);
        expect_burst(1, 12'h040, 5'd2, n);
        expect_burst(3, 12'h080, 5'd2, n + 3);
        expect_burst(1, 12'h040, 5'd2, n + 6);
        expect_burst(3, 12'h080, 5'd2, n + 9);
        expect_burst(1, 12'h040, 5'd2, n + 12);
        repeat (10) tick();
        apply_stimulus(2, 12'h0C0, 5'd1);
        expect_burst(2, 12'h0C0, 5'd1, n + 15);
        expect_burst(3, 12'h080, 5'd2, n + 17);
        repeat (8) tick();
        hold_mask = 4'b0000;
        bus.req   = '0;
        repeat (5) tick();

        $display("[TB] length and address boundaries");
        n = cyc;
        apply_stimulus(0, 12'h020, 5'd0);
        expect_burst(0, 12'h020, 5'd0, n);
        repeat (4) tick();
        m = cyc;
        apply_stimulus(1, 12'hFFC, 5'd16);
        expect_burst(1, 12'hFFC, 5'd16, m);
        tick();
        apply_stimulus(3, 12'h340, 5'd1);
        apply_stimulus(0, 12'h200, 5'd31);
        expect_burst(0, 12'h200, 5'd31, m + 17);
        repeat (4) tick();
        bus.req[3] = 1'b0;
        repeat (32) tick();

        $display("[TB] layer done during burst");
        n = cyc;
        apply_stimulus(0, 12'h300, 5'd9);
        expect_burst(0, 12'h300, 5'd9, n);
        repeat (2) tick();
        apply_stimulus(2, 12'h0C0, 5'd2);
        tick();
        bus.layer_done_in = 1'b1;
        check_output("ld_busy", 64'(bus.layer_done_out), 64'd0);
        repeat (7) tick();
        check_output("ld_last_data", 64'(bus.layer_done_out), 64'd0);
        tick();
        check_output("ld_set", 64'(bus.layer_done_out), 64'd1);
        repeat (4) tick();
        bus.req           = '0;
        bus.layer_done_in = 1'b0;
        repeat (3) tick();
        check_output("ld_sticky", 64'(bus.layer_done_out), 64'd1);

        $display("[TB] reset mid burst");
        do_reset(2);
        check_output("ld_reset_clear", 64'(bus.layer_done_out), 64'd0);
        n = cyc;
        apply_stimulus(2, 12'h500, 5'd4);
        grant_q.push_back('{lane: 2, cyc: n});
        read_q.push_back('{addr: 12'h500, cyc: n + 1});
        read_q.push_back('{addr: 12'h504, cyc: n + 2});
        rsp_q.push_back('{lane: 2, idx: 0, data: sram_word(12'h500), done: 1'b0, cyc: n + 2});
        repeat (3) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_output("abort_no_valid", 64'(bus.rdata_valid), 64'd0);
        check_output("abort_no_read", 64'(bus.mem_rd_en), 64'd0);
        apply_stimulus(0, 12'h600, 5'd2);
        apply_stimulus(1, 12'h700, 5'd3);
        expect_burst(0, 12'h600, 5'd2, n + 4);
        expect_burst(1, 12'h700, 5'd3, n + 7);
        repeat (10) tick();

        check_output("grant_q_left", 64'(grant_q.size()), 64'd0);
        check_output("read_q_left", 64'(read_q.size()), 64'd0);
        check_output("rsp_q_left", 64'(rsp_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
